// File: rtl/wb_mem_responder_if.sv
// wb_mem_responder_if: pipelined Wishbone B4 bus bundle between a master and the memory responder.
interface wb_mem_responder_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_stall_o;
    logic [15:0] wb_addr_i;
    logic        wb_we_i;
    logic [15:0] wb_dat_i;
    logic        wb_ack_o;
    logic [15:0] wb_data_o;
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_addr_i, wb_we_i, wb_dat_i,
        output wb_stall_o, wb_ack_o, wb_data_o
    );
    modport master (
        output wb_cyc_i, wb_stb_i, wb_addr_i, wb_we_i, wb_dat_i,
        input  wb_stall_o, wb_ack_o, wb_data_o
    );
endinterface

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: pipelined Wishbone B4 16-bit RAM responder with fixed ack latency.
// Define WB_MEM_RANDOM_STALL_EN to enable LFSR-driven random stalls (at most 3 in a row).
module wb_mem_responder #(
    parameter int G_ADDR_BITS = 8,
    parameter int G_LATENCY   = 1
) (
    input logic                clk_i,
    input logic                rst_i,
    wb_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** G_ADDR_BITS;

    logic [15:0]            mem_q [DEPTH];
    logic [G_LATENCY-1:0]   vld_q, vld_d;
    logic [15:0]            dat_q [G_LATENCY];
    logic [15:0]            dat_d [G_LATENCY];
    logic [G_ADDR_BITS-1:0] idx;
    logic                   stall;
    logic                   accept;

    assign idx    = bus.wb_addr_i[G_ADDR_BITS-1:0];
    assign accept = bus.wb_cyc_i & bus.wb_stb_i & ~stall & ~rst_i;

    // Reads sample the array before this cycle's write lands.
    always_ff @(posedge clk_i)
        if (accept && bus.wb_we_i) mem_q[idx] <= bus.wb_dat_i;

    always_comb begin
        vld_d[0] = accept;
        dat_d[0] = (accept && !bus.wb_we_i) ? mem_q[idx] : 16'h0000;
        for (int i = 1; i < G_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        if (!bus.wb_cyc_i) begin
            vld_d = '0;
            dat_d = '{default: '0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '{default: '0};
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign bus.wb_ack_o  = vld_q[G_LATENCY-1];
    assign bus.wb_data_o = dat_q[G_LATENCY-1];

`ifdef WB_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;
    logic [1:0]  run_q;
    logic        stall_q, stall_d;

    // run_q counts consecutive stalled cycles so the stall can be cut at three.
    assign stall_d = lfsr_q[0] & lfsr_q[5] & (run_q != 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q  <= 16'hACE1;
            run_q   <= 2'd0;
            stall_q <= 1'b0;
        end else begin
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            run_q   <= stall_d ? run_q + 2'd1 : 2'd0;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    assign bus.wb_stall_o = stall;
endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Pipelined Wishbone B4 slave (responder): word-addressed 16-bit RAM serving read and write requests from bus masters such as the instruction fetch stage.
- Used as the bus target in block-level benches and in the CPU system.
- Fixed response latency.
- Accepts one request per cycle when not stalling, so back-to-back pipelined reads receive back-to-back acks.

Parameters:
- G_ADDR_BITS, 8, memory depth is 2**G_ADDR_BITS 16-bit words; wb_addr_i bits above this are ignored (aliasing).
- G_LATENCY, 1, cycles from request acceptance to ack; legal range 1..4.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  request strobe.
- wb_stall_o  out  1  request not accepted this cycle.
- wb_addr_i  in  16  word address.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_dat_i  in  16  write data.
- wb_ack_o  out  1  response valid.
- wb_data_o  out  16  read data.

Behaviour:
- Clocking and reset:
  - One clock (clk_i).
  - Reset rst_i is synchronous and active-high.
  - Reset values: wb_ack_o=0, wb_data_o=0x0000, wb_stall_o=0, all pipeline valid bits cleared.
  - RAM contents are zero-initialised at configuration and are not affected by rst_i.
- Acceptance:
  - A request is accepted in cycle N iff wb_cyc_i & wb_stb_i & !wb_stall_o & !rst_i.
- Write:
  - RAM[addr mod 2**G_ADDR_BITS] is updated at the end of cycle N.
  - Ack is issued at cycle N+G_LATENCY with wb_data_o=0x0000.
- Read:
  - Data is the RAM contents after all writes accepted before cycle N; a write accepted in the same cycle N is not visible.
  - wb_ack_o=1 and wb_data_o=data exactly at cycle N+G_LATENCY.
- Pipelining:
  - Shift pipeline of G_LATENCY stages, each holding {valid, data}.
  - Every accepted request produces exactly one ack, in order.
  - At most G_LATENCY requests are outstanding.
  - No backpressure on acks; the master must accept them.
- Ack and data outputs:
  - wb_ack_o is high only for one cycle per request.
  - wb_data_o is 0x0000 whenever wb_ack_o=0.
- Cycle abort:
  - When wb_cyc_i=0 in any cycle, all pipeline valid bits are cleared that cycle and wb_ack_o=0 next cycle, so in-flight responses are discarded.
  - Writes already accepted remain committed.
- Reset mid-operation:
  - Pipeline is flushed and no ack is emitted for requests accepted before reset.
  - RAM writes already committed persist.
- Stall (macro absent): wb_stall_o is constantly 0.
- Protocol guarantees (asserted in formal):
  - No ack without a matching accepted request.
  - Outstanding count is ≤ G_LATENCY.
  - Ack never occurs while wb_cyc_i was low in the previous cycle.

Optional Feature:
- Macro: WB_MEM_RANDOM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; reset seed 0xACE1.
  - The stall request is lfsr[0] & lfsr[5].
  - wb_stall_o is registered and forced to 0 when a 2-bit counter shows 3 consecutive stall cycles, so stall never exceeds 3 cycles.
  - Stall has no effect on the ack pipeline.
- When undefined: wb_stall_o tied 0; no LFSR logic is synthesised.

Test Plan:
- Write then read, G_LATENCY=1: write 0x1234 to addr 0x0005 at cycle 1, read 0x0005 at cycle 2 → ack at cycle 2 with data 0x0000, ack at cycle 3 with wb_data_o=0x1234.
- Pipelined burst, G_LATENCY=2: preload addrs 0..3 with ~addr; reads at cycles 10,11,12,13 → acks at cycles 12..15 with data 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC.
- Aliasing, G_ADDR_BITS=8: write 0xBEEF to 0x0103, read 0x0003 → wb_data_o=0xBEEF.
- Cycle abort, G_LATENCY=3: read accepted at cycle 20, wb_cyc_i=0 at cycle 21 → no ack at cycle 23; a following write is still ack'd normally.
- Reset mid-burst, G_LATENCY=2: reads at cycles 30 and 31, rst_i=1 at cycle 31 → no acks at cycles 32–33, wb_stall_o=0; earlier written data still readable afterwards.
- With WB_MEM_RANDOM_STALL_EN: 1000 random requests → never more than 3 consecutive stall cycles; ack count equals accepted count; every read returns the last written value.
